// File: rtl/ybus_pkg.sv
// Shared types for the Y-bus transmitter: word types, controller states and the
// registered bus word.
package ybus_pkg;

  localparam int YB_DATA_W = 16;
  localparam int YB_TAG_W  = 8;

  typedef enum logic [1:0] {
    WT_IFMAP = 2'd0,
    WT_FLTR  = 2'd1,
    WT_PSUM  = 2'd2,
    WT_RSVD  = 2'd3
  } word_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WAIT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } tx_state_t;

  typedef struct packed {
    logic [YB_DATA_W-1:0] data;
    word_type_t           wtype;
    logic [YB_TAG_W-1:0]  y_tag;
    logic [YB_TAG_W-1:0]  x_tag;
  } ybus_word_t;

endpackage

// File: rtl/ybus_tag_cnt.sv
// One (row, col) tag counter pair. Column wraps at len; the row optionally wraps
// at row_len, otherwise it rolls over at the natural counter width.
module ybus_tag_cnt #(
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 advance,
  input  logic                 row_wrap,
  input  logic [TAG_WIDTH-1:0] len,
  input  logic [TAG_WIDTH-1:0] row_len,
  output logic [TAG_WIDTH-1:0] row,
  output logic [TAG_WIDTH-1:0] col
);

  localparam logic [TAG_WIDTH-1:0] ONE = TAG_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == len - ONE) begin
        col <= '0;
        row <= (row_wrap && row == row_len - ONE) ? '0 : row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end

endmodule

// File: rtl/ybus_tx_ctrl.sv
// Y-bus transmitter: flushes the array's tag allocators, waits for the array to
// go idle, then streams typed, tagged words through a one-deep output register.
module ybus_tx_ctrl
  import ybus_pkg::*;
#(
  parameter int DATA_WIDTH = YB_DATA_W,
  parameter int NUM_ROW    = 7,
  parameter int NUM_COL    = 7,
  parameter int TAG_WIDTH  = YB_TAG_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [7:0]            kernel_size,
  input  logic [TAG_WIDTH-1:0]  ifmap_width,
  input  logic [TAG_WIDTH-1:0]  ofmap_width,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [1:0]            s_type,
  input  logic                  s_last,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic [1:0]            bus_type,
  output logic [TAG_WIDTH-1:0]  bus_y_tag,
  output logic [TAG_WIDTH-1:0]  bus_x_tag,
  output logic                  load_ifmap,
  output logic                  load_fltr,
  output logic                  load_psum,
  output logic                  flush_tag,
  input  logic                  tag_busy,
  input  logic                  kernel_busy,
  input  logic                  ram_rst_busy,
  output logic                  done,
  output logic                  err
);

  // The bus word struct is sized by the package, so the geometry must match it.
  if (NUM_ROW < 1 || NUM_COL < 1 || DATA_WIDTH != YB_DATA_W || TAG_WIDTH != YB_TAG_W) begin : g_bad_params
    $error("ybus_tx_ctrl: unsupported parameter set");
  end

  tx_state_t            state_q, state_d;
  logic [7:0]           ks_q, flush_cnt_q;
  logic [TAG_WIDTH-1:0] ifmap_w_q, ofmap_w_q;
  logic                 err_q;
  logic                 cfg_bad, accept, rsvd, cnt_clear;
  logic [2:0]           adv;
  logic [TAG_WIDTH-1:0] len [3];
  logic [TAG_WIDTH-1:0] row [3];
  logic [TAG_WIDTH-1:0] col [3];
  logic [TAG_WIDTH-1:0] tag_y, tag_x;
  ybus_word_t           word_p1;
  logic                 vld_p1;

  assign cfg_bad   = (kernel_size == 8'd0) || (kernel_size > 8'(NUM_ROW)) ||
                     (ifmap_width == '0) || (ofmap_width == '0);
  assign accept    = s_valid && s_ready;
  assign rsvd      = (s_type == WT_RSVD);
  assign cnt_clear = (state_q == ST_WAIT) && (state_d == ST_STREAM);

  always_comb begin
    state_d   = state_q;
    flush_tag = 1'b0;
    done      = 1'b0;
    s_ready   = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (cfg_start && !cfg_bad) state_d = ST_FLUSH;
      ST_FLUSH: begin
        flush_tag = 1'b1;
        if (flush_cnt_q == ks_q - 8'd1) state_d = ST_WAIT;
      end
      ST_WAIT:   if (!(tag_busy || kernel_busy || ram_rst_busy)) state_d = ST_STREAM;
      ST_STREAM: begin
        // Gated by abort so no word is taken in the cycle the pass is torn down.
        s_ready = !cfg_abort && (!vld_p1 || bus_ready);
        if (s_valid && s_ready && s_last) state_d = ST_DRAIN;
      end
      ST_DRAIN:  if (!vld_p1 || bus_ready) state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (cfg_abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      ks_q        <= '0;
      ifmap_w_q   <= '0;
      ofmap_w_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= (state_q == ST_FLUSH && !cfg_abort) ? flush_cnt_q + 8'd1 : 8'd0;
      if (state_q == ST_IDLE && cfg_start && !cfg_abort) begin
        ks_q      <= kernel_size;
        ifmap_w_q <= ifmap_width;
        ofmap_w_q <= ofmap_width;
        err_q     <= cfg_bad;
      end else if (accept && rsvd) begin
        err_q <= 1'b1;
      end
    end
  end

  assign len[0] = ifmap_w_q;
  assign len[1] = TAG_WIDTH'(ks_q);
  assign len[2] = ofmap_w_q;

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    assign adv[i] = accept && (s_type == 2'(i));
    ybus_tag_cnt #(.TAG_WIDTH(TAG_WIDTH)) u_cnt (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (cnt_clear),
      .advance (adv[i]),
      .row_wrap((i == 1) ? 1'b1 : 1'b0),
      .len     (len[i]),
      .row_len (TAG_WIDTH'(ks_q)),
      .row     (row[i]),
      .col     (col[i])
    );
  end

  always_comb begin
    tag_y = row[0];
    tag_x = col[0];
    case (s_type)
      2'd1:    begin tag_y = row[1]; tag_x = col[1]; end
      2'd2:    begin tag_y = row[2]; tag_x = col[2]; end
      default: ;
    endcase
  end

  // ---- stage p1: bus output register ----
  always_ff @(posedge clk) begin
    if (!rstn || cfg_abort) vld_p1 <= 1'b0;
    else if (accept)        vld_p1 <= !rsvd;
    else if (bus_ready)     vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept && !rsvd) begin
      word_p1.data  <= YB_DATA_W'(s_data);
      word_p1.wtype <= word_type_t'(s_type);
      word_p1.y_tag <= YB_TAG_W'(tag_y);
      word_p1.x_tag <= YB_TAG_W'(tag_x);
    end
  end

  assign bus_valid  = vld_p1;
  assign bus_data   = vld_p1 ? DATA_WIDTH'(word_p1.data) : '0;
  assign bus_type   = vld_p1 ? word_p1.wtype : 2'd0;
  assign bus_y_tag  = vld_p1 ? TAG_WIDTH'(word_p1.y_tag) : '0;
  assign bus_x_tag  = vld_p1 ? TAG_WIDTH'(word_p1.x_tag) : '0;
  assign load_ifmap = vld_p1 && (word_p1.wtype == WT_IFMAP);
  assign load_fltr  = vld_p1 && (word_p1.wtype == WT_FLTR);
  assign load_psum  = vld_p1 && (word_p1.wtype == WT_PSUM);
  assign err        = err_q;

endmodule

// File: tb/tb_ybus_tx_ctrl.sv
// Bench for ybus_tx_ctrl: cycle model of the pass sequencing with tags derived
// from per-type word counts, plus directed scenarios with literal expectations.
module tb_ybus_tx_ctrl;
  localparam int DW = 16, TW = 8, NR = 7, NC = 7;
  localparam int P_IDLE = 0, P_FLUSH = 1, P_WAIT = 2, P_STREAM = 3, P_DRAIN = 4, P_DONE = 5;

  logic clk = 0, rstn = 0, cfg_start = 0, cfg_abort = 0;
  logic [7:0] kernel_size = 0;
  logic [TW-1:0] ifmap_width = 0, ofmap_width = 0;
  logic s_valid = 0, s_ready, s_last = 0;
  logic [DW-1:0] s_data = 0;
  logic [1:0] s_type = 0;
  logic bus_valid, bus_ready = 1;
  logic [DW-1:0] bus_data;
  logic [1:0] bus_type;
  logic [TW-1:0] bus_y_tag, bus_x_tag;
  logic load_ifmap, load_fltr, load_psum, flush_tag, done, err;
  logic tag_busy = 0, kernel_busy = 0, ram_rst_busy = 0;

  ybus_tx_ctrl #(.DATA_WIDTH(DW), .NUM_ROW(NR), .NUM_COL(NC), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .kernel_size(kernel_size), .ifmap_width(ifmap_width), .ofmap_width(ofmap_width),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_type(s_type), .s_last(s_last),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_data(bus_data), .bus_type(bus_type),
    .bus_y_tag(bus_y_tag), .bus_x_tag(bus_x_tag), .load_ifmap(load_ifmap),
    .load_fltr(load_fltr), .load_psum(load_psum), .flush_tag(flush_tag),
    .tag_busy(tag_busy), .kernel_busy(kernel_busy), .ram_rst_busy(ram_rst_busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errs = 0;
  function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endfunction

  // bus_ready driver: a queued pattern first, then the default level
  logic rdy_q[$];
  logic rdy_default = 1;
  always @(posedge clk) begin
    #1;
    if (rdy_q.size() > 0) bus_ready = rdy_q.pop_front();
    else bus_ready = rdy_default;
  end

  // ---------------- behavioural model ----------------
  int m_phase = P_IDLE, m_fcnt = 0, m_n[3];
  int m_ks = 0, m_iw = 0, m_ow = 0;
  int m_data = 0, m_type = 0, m_y = 0, m_x = 0;
  logic m_vld = 0, m_err = 0;
  bit m_on = 0;

  function automatic logic exp_ready();
    return (m_phase == P_STREAM) && !cfg_abort && (!m_vld || bus_ready);
  endfunction

  always @(posedge clk) begin : model
    logic acc, hs, bad;
    int t, l;
    if (!rstn) begin
      m_phase = P_IDLE; m_vld = 0; m_err = 0; m_fcnt = 0;
      for (int i = 0; i < 3; i++) m_n[i] = 0;
      m_on = 1;
    end else begin
      acc = s_valid && exp_ready();
      hs  = m_vld && bus_ready;
      if (cfg_abort) begin
        m_phase = P_IDLE; m_vld = 0;
      end else begin
        case (m_phase)
          P_IDLE: if (cfg_start) begin
            bad = (kernel_size == 0) || (kernel_size > NR) || (ifmap_width == 0) || (ofmap_width == 0);
            m_ks = kernel_size; m_iw = ifmap_width; m_ow = ofmap_width; m_err = bad;
            if (!bad) begin m_phase = P_FLUSH; m_fcnt = 0; end
          end
          P_FLUSH: begin
            m_fcnt++;
            if (m_fcnt == m_ks) m_phase = P_WAIT;
          end
          P_WAIT: if (!tag_busy && !kernel_busy && !ram_rst_busy) begin
            m_phase = P_STREAM;
            for (int i = 0; i < 3; i++) m_n[i] = 0;
          end
          P_STREAM: begin
            if (hs) m_vld = 0;
            if (acc) begin
              if (s_type == 2'd3) m_err = 1;
              else begin
                t = int'(s_type);
                l = (t == 0) ? m_iw : (t == 1) ? m_ks : m_ow;
                m_x = m_n[t] % l;
                m_y = m_n[t] / l;
                if (t == 1) m_y = m_y % m_ks;
                m_y = m_y % 256;
                m_n[t]++;
                m_vld = 1; m_data = int'(s_data); m_type = t;
              end
              if (s_last) m_phase = P_DRAIN;
            end
          end
          P_DRAIN: begin
            if (!m_vld || bus_ready) m_phase = P_DONE;
            if (hs) m_vld = 0;
          end
          P_DONE: m_phase = P_IDLE;
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  // ---------------- compare / monitor ----------------
  typedef struct { int t; int y; int x; int d; int c; } hs_t;
  hs_t hs_q[$];
  int cyc = 0, flush_seen = 0, done_seen = 0, done_cyc = -1;
  logic prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [TW-1:0] prev_y, prev_x;

  always @(negedge clk) begin
    cyc++;
    if (m_on) begin
      chk("bus_valid", bus_valid, m_vld);
      chk("s_ready", s_ready, exp_ready());
      chk("flush_tag", flush_tag, m_phase == P_FLUSH);
      chk("done", done, m_phase == P_DONE);
      chk("err", err, m_err);
      chk("load_ifmap", load_ifmap, m_vld && m_type == 0);
      chk("load_fltr", load_fltr, m_vld && m_type == 1);
      chk("load_psum", load_psum, m_vld && m_type == 2);
      if (m_vld && bus_valid) begin
        chk("bus_data", bus_data, m_data);
        chk("bus_type", bus_type, m_type);
        chk("bus_y_tag", bus_y_tag, m_y);
        chk("bus_x_tag", bus_x_tag, m_x);
      end
    end
    if (prev_stall) begin
      chk("hold_valid", bus_valid, 1);
      chk("hold_data", bus_data, prev_data);
      chk("hold_tags", {bus_y_tag, bus_x_tag}, {prev_y, prev_x});
    end
    prev_stall = bus_valid && !bus_ready && rstn && !cfg_abort;
    prev_data = bus_data; prev_y = bus_y_tag; prev_x = bus_x_tag;
    if (bus_valid && bus_ready)
      hs_q.push_back('{int'(bus_type), int'(bus_y_tag), int'(bus_x_tag), int'(bus_data), cyc});
    if (flush_tag) flush_seen++;
    if (done) begin done_seen++; done_cyc = cyc; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_pass(input int ks, input int iw, input int ow);
    kernel_size = 8'(ks); ifmap_width = TW'(iw); ofmap_width = TW'(ow);
    cfg_start = 1;
    tick();
    cfg_start = 0;
  endtask

  task automatic wait_stream();
    int k = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      if (++k > 100) begin chk("stream_timeout", s_ready, 1); break; end
    end
    tick();
  endtask

  task automatic send(input logic [1:0] t, input logic [DW-1:0] d, input logic l);
    int k = 0;
    s_valid = 1; s_type = t; s_data = d; s_last = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      if (++k > 100) begin chk("send_timeout", s_ready, 1); break; end
    end
    tick();
    s_valid = 0; s_last = 0;
  endtask

  task automatic wait_done();
    int k = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (++k > 100) begin chk("done_timeout", done, 1); break; end
    end
    tick();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_valid"}, bus_valid, 0);
    chk({nm, "_ready"}, s_ready, 0);
    chk({nm, "_flush"}, flush_tag, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_loads"}, {load_ifmap, load_fltr, load_psum}, 0);
    chk({nm, "_payload"}, {bus_data, bus_type, bus_y_tag, bus_x_tag}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int fy[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int fx[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int by[5] = '{0, 0, 0, 0, 1};
    int bx[5] = '{0, 1, 2, 3, 0};
    int it[8] = '{0, 2, 0, 2, 0, 2, 0, 2};
    int iy[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    int ix[8] = '{0, 0, 1, 1, 2, 0, 0, 1};
    int d0;

    tick(); tick();
    @(negedge clk); check_zero("reset");
    tick();
    rstn = 1;
    tick();

    // filter pass, kernel 3: flush length, tags, throughput, done timing
    hs_q.delete(); flush_seen = 0;
    start_pass(3, 4, 2);
    wait_stream();
    chk("flush_cycles", flush_seen, 3);
    for (int i = 0; i < 9; i++) send(2'd1, DW'(16'h100 + i), i == 8);
    wait_done();
    chk("fltr_count", hs_q.size(), 9);
    for (int i = 0; i < 9 && i < hs_q.size(); i++) begin
      chk("fltr_y", hs_q[i].y, fy[i]);
      chk("fltr_x", hs_q[i].x, fx[i]);
      chk("fltr_data", hs_q[i].d, 16'h100 + i);
      chk("fltr_consecutive", hs_q[i].c, hs_q[0].c + i);
    end
    if (hs_q.size() == 9) chk("done_after_last", done_cyc, hs_q[8].c + 1);

    // ifmap backpressure, width 4
    hs_q.delete();
    start_pass(3, 4, 2);
    wait_stream();
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) send(2'd0, DW'(16'h200 + i), i == 4);
    wait_done();
    chk("bp_count", hs_q.size(), 5);
    for (int i = 0; i < 5 && i < hs_q.size(); i++) begin
      chk("bp_y", hs_q[i].y, by[i]);
      chk("bp_x", hs_q[i].x, bx[i]);
      chk("bp_data", hs_q[i].d, 16'h200 + i);
    end

    // interleaved ifmap (width 3) and psum (width 2)
    hs_q.delete();
    start_pass(3, 3, 2);
    wait_stream();
    for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 2'd0 : 2'd2, DW'(16'h300 + i), i == 7);
    wait_done();
    chk("il_count", hs_q.size(), 8);
    for (int i = 0; i < 8 && i < hs_q.size(); i++) begin
      chk("il_type", hs_q[i].t, it[i]);
      chk("il_y", hs_q[i].y, iy[i]);
      chk("il_x", hs_q[i].x, ix[i]);
    end

    // configuration error: kernel 8 exceeds the row count
    flush_seen = 0;
    start_pass(8, 4, 2);
    @(negedge clk); chk("cfg_err", err, 1);
    tick(); tick(); tick(); tick();
    chk("cfg_err_no_flush", flush_seen, 0);

    // reserved word mid-stream is dropped without touching the counters
    hs_q.delete();
    start_pass(3, 4, 2);
    @(negedge clk); chk("err_cleared", err, 0);
    tick();
    wait_stream();
    send(2'd0, 16'h0011, 0);
    send(2'd3, 16'h0022, 0);
    send(2'd0, 16'h0033, 1);
    wait_done();
    chk("rsvd_err", err, 1);
    chk("rsvd_count", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      chk("rsvd_w1_x", hs_q[1].x, 1);
      chk("rsvd_w1_data", hs_q[1].d, 16'h0033);
    end

    // abort with a stalled word on the bus
    d0 = done_seen;
    start_pass(3, 4, 2);
    wait_stream();
    rdy_default = 0;
    tick();
    send(2'd0, 16'h0044, 0);
    @(negedge clk);
    chk("abort_pre_valid", bus_valid, 1);
    chk("abort_pre_ready", bus_ready, 0);
    tick();
    cfg_abort = 1;
    tick();
    cfg_abort = 0;
    @(negedge clk);
    chk("abort_valid", bus_valid, 0);
    chk("abort_ready", s_ready, 0);
    tick(); tick(); tick();
    chk("abort_no_done", done_seen, d0);
    rdy_default = 1;
    tick();

    // tag_busy held through flush and into WAIT
    flush_seen = 0;
    tag_busy = 1;
    start_pass(2, 4, 2);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); chk("busy_hold", s_ready, 0);
      tick();
    end
    chk("busy_flush_cycles", flush_seen, 2);
    tag_busy = 0;
    @(negedge clk); chk("busy_release_wait", s_ready, 0);
    tick();
    @(negedge clk); chk("busy_release_stream", s_ready, 1);
    tick();
    send(2'd0, 16'h0055, 1);
    wait_done();

    // reset in the middle of a stream
    start_pass(3, 4, 2);
    wait_stream();
    rdy_default = 0;
    tick();
    send(2'd1, 16'h0077, 0);
    @(negedge clk); chk("pre_rst_valid", bus_valid, 1);
    tick();
    rstn = 0;
    tick();
    @(negedge clk); check_zero("rst_mid");
    tick();
    rstn = 1;
    rdy_default = 1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
